// File: rtl/vseq_pkg.sv
// -----------------------------------------------------------------------------
// vseq_pkg
// Shared definitions for the vector-add request sequencer:
//   - state_t          : sequencer FSM states
//   - PIPE_LAT_DEFAULT : default adder-pipeline latency in cycles
//   - SEW_*            : element-width encodings carried on instr_sew/alu_sew
//   - epb()            : elements carried by one datapath beat for a given SEW
// -----------------------------------------------------------------------------
package vseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned PIPE_LAT_DEFAULT = 6;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  // Elements per beat: a beat carries bytes_per_beat bytes, each element is
  // 2**sew bytes wide.
  function automatic int unsigned epb(input int unsigned bytes_per_beat,
                                      input logic [1:0]  sew);
    return bytes_per_beat >> sew;
  endfunction

endpackage

// File: rtl/vseq_delay_pipe.sv
// -----------------------------------------------------------------------------
// vseq_delay_pipe
// Fixed-depth register delay line used to align per-beat control fields with
// operand read data. DEPTH = 0 degenerates to a wire.
// Ports:
//   clk  in  1      : clock
//   rst  in  1      : synchronous active-high reset, clears every stage
//   din  in  WIDTH  : value entering the pipe
//   dout out WIDTH  : value that entered DEPTH cycles earlier
// -----------------------------------------------------------------------------
module vseq_delay_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // NOTE: the stages are cleared on reset, unlike a plain data delay line,
      // so a beat that was in flight cannot emerge after an aborted
      // instruction. Sequential state is always updated with <= so every
      // stage samples its predecessor's old value on the same edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= din;
          for (int i = 1; i < int'(DEPTH); i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vadd_req_sequencer.sv
// -----------------------------------------------------------------------------
// vadd_req_sequencer
// Accepts one vector-add instruction at a time, splits it into datapath beats,
// issues operand reads one beat per unstalled cycle, forwards per-beat control
// to the adder datapath aligned with the read data, then waits for the adder
// pipeline to drain before pulsing done.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   instr_valid / instr_ready     : instruction handshake (ready only in IDLE)
//   instr_vl, instr_sew           : element count, element width
//   instr_opsel                   : opcode select
//   instr_carry/avg/mask          : mode flags
//   instr_vs1/vs2/vd              : operand and destination base word addresses
//   stall                         : hold beat issue this cycle
//   rd_en, rd_addr1, rd_addr2     : operand read strobe and addresses
//   alu_valid                     : beat valid to the datapath (RD_LAT after rd_en)
//   alu_sew/opsel/carry/avg/mask  : per-beat copies of the instruction fields
//   alu_addr                      : destination word address of the beat
//   alu_start_idx                 : mask bit offset of the beat's first element
//   alu_req_start / alu_req_end   : first / last beat markers
//   alu_be                        : byte enables (tail-trimmed on a partial beat)
//   busy                          : instruction in ISSUE or DRAIN
//   done                          : completion pulse
//   err                           : rejection pulse (unsupported SEW)
// -----------------------------------------------------------------------------
module vadd_req_sequencer
  import vseq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned VL_WIDTH      = 16,
  parameter int unsigned OPSEL_WIDTH   = 9,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned PIPE_LAT      = PIPE_LAT_DEFAULT,
  parameter bit          ENABLE_64_BIT = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [VL_WIDTH-1:0]     instr_vl,
  input  logic [1:0]              instr_sew,
  input  logic [OPSEL_WIDTH-1:0]  instr_opsel,
  input  logic                    instr_carry,
  input  logic                    instr_avg,
  input  logic                    instr_mask,
  input  logic [ADDR_WIDTH-1:0]   instr_vs1,
  input  logic [ADDR_WIDTH-1:0]   instr_vs2,
  input  logic [ADDR_WIDTH-1:0]   instr_vd,

  input  logic                    stall,

  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr1,
  output logic [ADDR_WIDTH-1:0]   rd_addr2,

  output logic                    alu_valid,
  output logic [1:0]              alu_sew,
  output logic [OPSEL_WIDTH-1:0]  alu_opsel,
  output logic                    alu_carry,
  output logic                    alu_avg,
  output logic                    alu_mask,
  output logic [ADDR_WIDTH-1:0]   alu_addr,
  output logic [5:0]              alu_start_idx,
  output logic                    alu_req_start,
  output logic                    alu_req_end,
  output logic [DATA_WIDTH/8-1:0] alu_be,

  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned BE_W      = DATA_WIDTH / 8;
  localparam int unsigned BE_LOG2   = $clog2(BE_W);
  localparam int unsigned CNT_W     = VL_WIDTH + 1;
  localparam int unsigned OFF_W     = CNT_W + BE_LOG2;
  // The drain counter runs 0..DRAIN_CYC-1; RD_LAT + PIPE_LAT must be >= 2.
  localparam int unsigned DRAIN_CYC = RD_LAT + PIPE_LAT;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC);

  // Everything the datapath needs about one beat, delayed as a single word.
  typedef struct packed {
    logic                   valid;
    logic [1:0]             sew;
    logic [OPSEL_WIDTH-1:0] opsel;
    logic                   carry;
    logic                   avg;
    logic                   mask;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [5:0]             start_idx;
    logic                   req_start;
    logic                   req_end;
    logic [BE_W-1:0]        be;
  } beat_t;

  // Latched instruction
  state_t                 state;
  logic [VL_WIDTH-1:0]    vl_q;
  logic [1:0]             sew_q;
  logic [OPSEL_WIDTH-1:0] opsel_q;
  logic                   carry_q;
  logic                   avg_q;
  logic                   mask_q;
  logic [ADDR_WIDTH-1:0]  vs1_q;
  logic [ADDR_WIDTH-1:0]  vs2_q;
  logic [ADDR_WIDTH-1:0]  vd_q;

  // Sequencing state
  logic [CNT_W-1:0]       beat_q;
  logic [CNT_W-1:0]       last_q;
  logic [DRAIN_W-1:0]     drain_q;
  logic                   done_q;
  logic                   err_q;

  // Combinational helpers
  logic                   accept;
  logic                   reject_new;
  logic [OFF_W-1:0]       epb_new;
  logic [OFF_W-1:0]       vl_pad;
  logic [CNT_W-1:0]       beats_new;
  logic                   issue;
  logic [OFF_W-1:0]       epb_cur;
  logic [OFF_W-1:0]       elem_off;
  logic [OFF_W-1:0]       rem;
  logic [OFF_W-1:0]       rem_bytes;
  logic                   partial;
  logic [BE_W-1:0]        be_beat;
  beat_t                  beat_in;
  beat_t                  beat_out;

  // ---------------------------------------------------------------------------
  // Handshake and instruction decode
  // ---------------------------------------------------------------------------
  // A done pulse is still in flight during its own cycle, so the next
  // instruction waits one more cycle even if the FSM is already in IDLE
  // (zero-length instruction case).
  assign instr_ready = (state == IDLE) && !done_q;
  assign accept      = instr_valid && instr_ready;
  assign reject_new  = (instr_sew == SEW_64) && !ENABLE_64_BIT;

  // Beat count = ceil(vl / epb); epb is a power of two so the divide is a shift.
  always_comb begin
    epb_new   = OFF_W'(epb(BE_W, instr_sew));
    vl_pad    = OFF_W'(instr_vl) + epb_new - OFF_W'(1);
    beats_new = CNT_W'(vl_pad >> (BE_LOG2 - int'(instr_sew)));
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vl_q    <= '0;
      sew_q   <= '0;
      opsel_q <= '0;
      carry_q <= 1'b0;
      avg_q   <= 1'b0;
      mask_q  <= 1'b0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            vl_q    <= instr_vl;
            sew_q   <= instr_sew;
            opsel_q <= instr_opsel;
            carry_q <= instr_carry;
            avg_q   <= instr_avg;
            mask_q  <= instr_mask;
            vs1_q   <= instr_vs1;
            vs2_q   <= instr_vs2;
            vd_q    <= instr_vd;
            beat_q  <= '0;
            last_q  <= beats_new - CNT_W'(1);
            if (reject_new) begin
              err_q <= 1'b1;
            end else if (instr_vl == '0) begin
              // Nothing to issue or drain: complete straight from IDLE.
              done_q <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (!stall) begin
            beat_q <= beat_q + CNT_W'(1);
            if (beat_q == last_q) begin
              state   <= DRAIN;
              drain_q <= '0;
            end
          end
        end

        DRAIN: begin
          // DRAIN lasts RD_LAT + PIPE_LAT cycles; done is registered, so it is
          // raised one count early to land in the final DRAIN cycle.
          drain_q <= drain_q + DRAIN_W'(1);
          if (drain_q == DRAIN_W'(DRAIN_CYC - 2)) begin
            done_q <= 1'b1;
          end
          if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign err  = err_q;

  // ---------------------------------------------------------------------------
  // Beat issue
  // ---------------------------------------------------------------------------
  assign issue    = (state == ISSUE) && !stall;
  assign rd_en    = issue;
  assign rd_addr1 = issue ? vs1_q + ADDR_WIDTH'(beat_q) : '0;
  assign rd_addr2 = issue ? vs2_q + ADDR_WIDTH'(beat_q) : '0;

  // First element of the beat, elements still remaining, and tail trimming.
  always_comb begin
    epb_cur   = OFF_W'(epb(BE_W, sew_q));
    elem_off  = OFF_W'(beat_q) << (BE_LOG2 - int'(sew_q));
    rem       = OFF_W'(vl_q) - elem_off;
    partial   = (beat_q == last_q) && (rem < epb_cur);
    rem_bytes = rem << sew_q;
    for (int i = 0; i < int'(BE_W); i++) begin
      be_beat[i] = !partial || (OFF_W'(i) < rem_bytes);
    end
  end

  // NOTE: every field gets a default before the conditional fill, which keeps
  // this block purely combinational and also forces all alu_* fields to zero
  // on cycles that carry no beat.
  always_comb begin
    beat_in = '0;
    if (issue) begin
      beat_in.valid     = 1'b1;
      beat_in.sew       = sew_q;
      beat_in.opsel     = opsel_q;
      beat_in.carry     = carry_q;
      beat_in.avg       = avg_q;
      beat_in.mask      = mask_q;
      beat_in.addr      = vd_q + ADDR_WIDTH'(beat_q);
      beat_in.start_idx = elem_off[5:0];
      beat_in.req_start = (beat_q == '0);
      beat_in.req_end   = (beat_q == last_q);
      beat_in.be        = be_beat;
    end
  end

  // Control travels alongside the operand read so it meets the read data.
  vseq_delay_pipe #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (RD_LAT)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (beat_in),
    .dout (beat_out)
  );

  assign alu_valid     = beat_out.valid;
  assign alu_sew       = beat_out.sew;
  assign alu_opsel     = beat_out.opsel;
  assign alu_carry     = beat_out.carry;
  assign alu_avg       = beat_out.avg;
  assign alu_mask      = beat_out.mask;
  assign alu_addr      = beat_out.addr;
  assign alu_start_idx = beat_out.start_idx;
  assign alu_req_start = beat_out.req_start;
  assign alu_req_end   = beat_out.req_end;
  assign alu_be        = beat_out.be;

endmodule

// File: tb/tb_vadd_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vadd_req_sequencer
// Self-checking bench for vadd_req_sequencer. Expected beats are pushed to a
// scoreboard when an instruction is presented and popped as alu_valid beats
// appear; read strobes, done/err/busy/ready timing are checked per cycle
// against a small schedule model.
// -----------------------------------------------------------------------------
module tb_vadd_req_sequencer;

  localparam int RD_LAT   = 1;
  localparam int PIPE_LAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_vl;
  logic [1:0]  instr_sew;
  logic [8:0]  instr_opsel;
  logic        instr_carry;
  logic        instr_avg;
  logic        instr_mask;
  logic [31:0] instr_vs1;
  logic [31:0] instr_vs2;
  logic [31:0] instr_vd;
  logic        stall;
  logic        rd_en;
  logic [31:0] rd_addr1;
  logic [31:0] rd_addr2;
  logic        alu_valid;
  logic [1:0]  alu_sew;
  logic [8:0]  alu_opsel;
  logic        alu_carry;
  logic        alu_avg;
  logic        alu_mask;
  logic [31:0] alu_addr;
  logic [5:0]  alu_start_idx;
  logic        alu_req_start;
  logic        alu_req_end;
  logic [7:0]  alu_be;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  vadd_req_sequencer #(
    .RD_LAT   (RD_LAT),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_vl      (instr_vl),
    .instr_sew     (instr_sew),
    .instr_opsel   (instr_opsel),
    .instr_carry   (instr_carry),
    .instr_avg     (instr_avg),
    .instr_mask    (instr_mask),
    .instr_vs1     (instr_vs1),
    .instr_vs2     (instr_vs2),
    .instr_vd      (instr_vd),
    .stall         (stall),
    .rd_en         (rd_en),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .alu_valid     (alu_valid),
    .alu_sew       (alu_sew),
    .alu_opsel     (alu_opsel),
    .alu_carry     (alu_carry),
    .alu_avg       (alu_avg),
    .alu_mask      (alu_mask),
    .alu_addr      (alu_addr),
    .alu_start_idx (alu_start_idx),
    .alu_req_start (alu_req_start),
    .alu_req_end   (alu_req_end),
    .alu_be        (alu_be),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  sidx;
    logic        rs;
    logic        re;
    logic [7:0]  be;
  } exp_t;

  exp_t sb[$];
  int   rd_cyc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit quiet();
    return !(rd_en || (|rd_addr1) || (|rd_addr2) || alu_valid || (|alu_sew) ||
             (|alu_opsel) || alu_carry || alu_avg || alu_mask || (|alu_addr) ||
             (|alu_start_idx) || alu_req_start || alu_req_end || (|alu_be) ||
             busy || done || err);
  endfunction

  // Presents one instruction, waits for acceptance, then checks every cycle up
  // to the expected done cycle plus 'tail'. exp_done < 0 lets the schedule
  // model derive the done offset.
  task automatic run_instr(input string name, input int vl, input int sew,
                           input int vs1, input int vs2, input int vd,
                           input int st_from, input int st_len,
                           input int exp_done, input int tail,
                           output int t_acc);
    int epb, beats, mb, last_rd, done_off, horizon, waited, rd_cnt, quiet_bad, lat;
    bit rej, stl, exp_rd, exp_busy, exp_ready;
    logic [8:0] opsel;
    logic carry, avg, mask;
    exp_t e;

    rej   = (sew == 3);
    epb   = 8 >> sew;
    beats = rej ? 0 : (vl + epb - 1) / epb;
    opsel = 9'(vl * 5 + sew + 1);
    carry = 1'(vl & 1);
    avg   = 1'((vl >> 1) & 1);
    mask  = 1'(vs1 & 1);

    mb = 0;
    last_rd = 0;
    for (int o = 1; mb < beats; o++) begin
      if (!(o >= st_from && o < st_from + st_len)) begin
        mb++;
        last_rd = o;
      end
    end
    if (rej)                done_off = -1;
    else if (exp_done >= 0) done_off = exp_done;
    else if (beats == 0)    done_off = 1;
    else                    done_off = last_rd + RD_LAT + PIPE_LAT;
    horizon = (rej ? 1 : done_off) + tail;

    instr_vl    = 16'(vl);
    instr_sew   = 2'(sew);
    instr_opsel = opsel;
    instr_carry = carry;
    instr_avg   = avg;
    instr_mask  = mask;
    instr_vs1   = 32'(vs1);
    instr_vs2   = 32'(vs2);
    instr_vd    = 32'(vd);
    instr_valid = 1'b1;

    waited = 0;
    while (!instr_ready && waited < 50) begin
      tick();
      waited++;
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept_timeout instr_ready=%b want=1", name, instr_ready);
      instr_valid = 1'b0;
      t_acc = -1;
      return;
    end
    t_acc = cyc;

    for (int b = 0; b < beats; b++) begin
      e.addr = 32'(vd + b);
      e.sidx = 6'((b * epb) % 64);
      e.rs   = (b == 0);
      e.re   = (b == beats - 1);
      if (b == beats - 1 && (vl - b * epb) < epb)
        e.be = 8'((1 << ((vl - b * epb) << sew)) - 1);
      else
        e.be = 8'hFF;
      sb.push_back(e);
    end

    tick();
    instr_valid = 1'b0;
    mb = 0;
    rd_cnt = 0;
    quiet_bad = 0;

    for (int o = 1; o <= horizon; o++) begin
      if (o > 1) tick();
      stl = (o >= st_from && o < st_from + st_len);
      stall = stl;
      #1;

      exp_rd = (mb < beats) && !stl;
      total++;
      if (rd_en !== exp_rd) begin
        bad++;
        $display("FAIL %s rd_en T+%0d got=%b want=%b", name, o, rd_en, exp_rd);
      end
      if (exp_rd) begin
        total++;
        if (rd_addr1 !== 32'(vs1 + mb) || rd_addr2 !== 32'(vs2 + mb)) begin
          bad++;
          $display("FAIL %s rd_addr T+%0d got=%h/%h want=%h/%h", name, o,
                   rd_addr1, rd_addr2, 32'(vs1 + mb), 32'(vs2 + mb));
        end
        mb++;
      end
      if (rd_en === 1'b1) begin
        rd_cnt++;
        rd_cyc_q.push_back(cyc);
      end

      if (alu_valid === 1'b1) begin
        total++;
        if (sb.size() == 0 || rd_cyc_q.size() == 0) begin
          bad++;
          $display("FAIL %s unexpected_beat T+%0d alu_addr=%h want=none", name, o, alu_addr);
        end else begin
          e   = sb.pop_front();
          lat = cyc - rd_cyc_q.pop_front();
          if (lat != RD_LAT) begin
            bad++;
            $display("FAIL %s beat_latency T+%0d got=%0d want=%0d", name, o, lat, RD_LAT);
          end
          total++;
          if ({alu_addr, alu_start_idx, alu_req_start, alu_req_end, alu_be} !==
              {e.addr, e.sidx, e.rs, e.re, e.be}) begin
            bad++;
            $display("FAIL %s beat_fields T+%0d got addr=%h idx=%0d s=%b e=%b be=%h want addr=%h idx=%0d s=%b e=%b be=%h",
                     name, o, alu_addr, alu_start_idx, alu_req_start, alu_req_end, alu_be,
                     e.addr, e.sidx, e.rs, e.re, e.be);
          end
          total++;
          if ({alu_sew, alu_opsel, alu_carry, alu_avg, alu_mask} !==
              {2'(sew), opsel, carry, avg, mask}) begin
            bad++;
            $display("FAIL %s beat_ctrl T+%0d got sew=%0d op=%h c=%b a=%b m=%b want sew=%0d op=%h c=%b a=%b m=%b",
                     name, o, alu_sew, alu_opsel, alu_carry, alu_avg, alu_mask,
                     sew, opsel, carry, avg, mask);
          end
        end
      end else if ({alu_sew, alu_opsel, alu_carry, alu_avg, alu_mask, alu_addr,
                    alu_start_idx, alu_req_start, alu_req_end, alu_be} !== '0) begin
        quiet_bad++;
      end

      total++;
      if (done !== (o == done_off)) begin
        bad++;
        $display("FAIL %s done T+%0d got=%b want=%b", name, o, done, (o == done_off));
      end
      total++;
      if (err !== (rej && o == 1)) begin
        bad++;
        $display("FAIL %s err T+%0d got=%b want=%b", name, o, err, (rej && o == 1));
      end
      exp_busy  = !rej && beats > 0 && o <= done_off;
      exp_ready = !exp_busy && (o != done_off);
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL %s busy T+%0d got=%b want=%b", name, o, busy, exp_busy);
      end
      total++;
      if (instr_ready !== exp_ready) begin
        bad++;
        $display("FAIL %s instr_ready T+%0d got=%b want=%b", name, o, instr_ready, exp_ready);
      end
    end
    stall = 1'b0;

    total++;
    if (quiet_bad != 0) begin
      bad++;
      $display("FAIL %s alu_idle_zero nonzero_cycles=%0d want=0", name, quiet_bad);
    end
    total++;
    if (rd_cnt != beats || sb.size() != 0) begin
      bad++;
      $display("FAIL %s beat_count reads=%0d left=%0d want reads=%0d left=0",
               name, rd_cnt, sb.size(), beats);
    end
    sb.delete();
    rd_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    total++;
    if (!quiet()) begin
      bad++;
      $display("FAIL reset outputs_zero got busy=%b done=%b err=%b rd_en=%b alu_valid=%b want=0",
               busy, done, err, rd_en, alu_valid);
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset instr_ready got=%b want=1", instr_ready);
    end
  endtask

  task automatic test_basic();
    int t;
    run_instr("basic_sew8", 20, 0, 'h10, 'h20, 'h30, 0, 0, 10, 3, t);
  endtask

  task automatic test_sew32();
    int t;
    run_instr("sew32_vl3", 3, 2, 'h40, 'h50, 'h60, 0, 0, 9, 3, t);
  endtask

  task automatic test_stall();
    int t;
    run_instr("stall", 20, 0, 'h10, 'h20, 'h30, 2, 2, 12, 3, t);
    run_instr("stall_first", 9, 1, 'h70, 'h80, 'h90, 1, 3, -1, 3, t);
  endtask

  task automatic test_vl_zero();
    int t;
    run_instr("vl_zero", 0, 0, 'h10, 'h20, 'h30, 0, 0, 1, 3, t);
  endtask

  task automatic test_reject();
    int t;
    run_instr("reject_sew64", 16, 3, 'h10, 'h20, 'h30, 0, 0, -1, 3, t);
  endtask

  task automatic test_patterns();
    int t;
    run_instr("full_beats", 64, 0, 'h100, 'h200, 'h300, 0, 0, -1, 3, t);
    run_instr("sew16_vl33", 33, 1, 'h1001, 'h2000, 'h3000, 0, 0, -1, 3, t);
    run_instr("single_elem", 1, 2, 'h5, 'h6, 'h7, 0, 0, -1, 3, t);
    run_instr("idx_wrap", 130, 0, 'hFF0, 'hEF0, 'hDF0, 0, 0, -1, 3, t);
  endtask

  task automatic test_back_to_back();
    int ta, tb;
    run_instr("b2b_first", 16, 0, 'h10, 'h20, 'h30, 0, 0, 9, 0, ta);
    run_instr("b2b_second", 12, 1, 'h11, 'h21, 'h31, 0, 0, -1, 3, tb);
    total++;
    if (tb != ta + 10) begin
      bad++;
      $display("FAIL b2b accept_cycle got=T+%0d want=T+10", tb - ta);
    end
  endtask

  task automatic test_reset_abort();
    int t, waited;
    instr_vl    = 16'd64;
    instr_sew   = 2'b00;
    instr_opsel = 9'h1A5;
    instr_carry = 1'b1;
    instr_avg   = 1'b1;
    instr_mask  = 1'b1;
    instr_vs1   = 32'h100;
    instr_vs2   = 32'h200;
    instr_vd    = 32'h300;
    instr_valid = 1'b1;
    waited = 0;
    while (!instr_ready && waited < 50) begin
      tick();
      waited++;
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort accept_timeout instr_ready=%b want=1", instr_ready);
    end
    t = cyc;
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (!quiet()) begin
      bad++;
      $display("FAIL abort outputs_zero T+%0d got rd_en=%b alu_valid=%b busy=%b done=%b want=0",
               cyc - t, rd_en, alu_valid, busy, done);
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort instr_ready got=%b want=1", instr_ready);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (done !== 1'b0 || alu_valid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort quiet T+%0d got done=%b alu_valid=%b rd_en=%b busy=%b want=0",
                 cyc - t, done, alu_valid, rd_en, busy);
      end
    end
    run_instr("after_abort", 20, 1, 'h400, 'h500, 'h600, 0, 0, -1, 3, t);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_vl    = '0;
    instr_sew   = '0;
    instr_opsel = '0;
    instr_carry = 1'b0;
    instr_avg   = 1'b0;
    instr_mask  = 1'b0;
    instr_vs1   = '0;
    instr_vs2   = '0;
    instr_vd    = '0;
    stall       = 1'b0;

    test_reset();
    test_basic();
    test_sew32();
    test_stall();
    test_vl_zero();
    test_reject();
    test_patterns();
    test_back_to_back();
    test_reset_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
